// File: rtl/bram_program_loader_pkg.sv
// Shared sizing and loader state encodings for the BRAM boot loader.
// States stay plain 3-bit constants so legacy tools and waveforms decode them the same way.
package bram_program_loader_pkg;

   localparam int RAM_ADDR_WIDTH = 12;
   localparam int DATA_WIDTH     = 32;
   localparam int RAM_SIZE_WORDS = 1024;
   localparam int BYTES_PER_WORD = 4;

   localparam logic [2:0] LDR_HDR0      = 3'd0;
   localparam logic [2:0] LDR_HDR1      = 3'd1;
   localparam logic [2:0] LDR_DATA      = 3'd2;
   localparam logic [2:0] LDR_REL_RST   = 3'd3;
   localparam logic [2:0] LDR_REL_STALL = 3'd4;
   localparam logic [2:0] LDR_RUN       = 3'd5;
   localparam logic [2:0] LDR_ERROR     = 3'd6;

   // Byte address of word number idx relative to base.
   function automatic logic [RAM_ADDR_WIDTH-1:0] word_byte_addr(
      input logic [RAM_ADDR_WIDTH-1:0] base,
      input logic [15:0]               idx
   );
      return base + RAM_ADDR_WIDTH'({idx, 2'b00});
   endfunction

endpackage

// File: rtl/bram_program_loader_byte_word_assembler.sv
// Little-endian 4-byte word assembler: first byte lands in [7:0], fourth in [31:24].
// o_word is captured on the fourth byte and held, so new bytes can stream in during the write cycle.
module bram_program_loader_byte_word_assembler #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [7:0]        i_byte,
   output logic [1:0]        o_byte_idx,
   output logic [DATA_W-1:0] o_word,
   output logic              o_word_valid
);

   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_word;
   logic [1:0]        r_idx;
   logic              r_vld;

   always_ff @(posedge clk) begin
      if (i_en)
         r_shift <= {i_byte, r_shift[DATA_W-1:8]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= 2'd0;
         r_vld  <= 1'b0;
         r_word <= '0;
      end else begin
         r_vld <= 1'b0;
         if (i_clr) begin
            r_idx <= 2'd0;
         end else if (i_en) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
               r_word <= {i_byte, r_shift[DATA_W-1:8]};
               r_vld  <= 1'b1;
            end
         end
      end
   end

   assign o_byte_idx   = r_idx;
   assign o_word       = r_word;
   assign o_word_valid = r_vld;

endmodule

// File: rtl/bram_program_loader.sv
// Boot loader: streams a counted little-endian image into the instruction BRAM,
// then releases the CPU (reset first, stall one cycle later).
module bram_program_loader
   import bram_program_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = bram_program_loader_pkg::DATA_WIDTH,
   parameter int MAX_WORDS  = RAM_SIZE_WORDS,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] w_dat,
   output logic                  w_enb,
   output logic [3:0]            byte_enb,
   output logic                  cpu_rst,
   output logic                  pc_stall,
   output logic                  done,
   output logic                  err
);

   localparam logic [15:0] LP_MAX = 16'(MAX_WORDS);

   logic [2:0]            r_state;
   logic [15:0]           r_count;
   logic [15:0]           r_word_idx;
   logic                  r_last;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_cpu_rst;
   logic                  r_pc_stall;
   logic                  r_done;
   logic                  r_err;

   logic                  w_ready;
   logic                  w_xfer;
   logic [15:0]           w_hdr_n;
   logic [1:0]            w_byte_idx;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_word_valid;

   // Once the last word's fourth byte is in, the host is throttled until release.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         LDR_HDR0, LDR_HDR1, LDR_ERROR: w_ready = 1'b1;
         LDR_DATA:                      w_ready = ~r_last;
         default:                       w_ready = 1'b0;
      endcase
      if (rst)
         w_ready = 1'b0;
   end

   assign w_xfer  = in_valid & w_ready;
   assign w_hdr_n = {in_data, r_count[7:0]};

   bram_program_loader_byte_word_assembler #(
      .DATA_W (DATA_WIDTH)
   ) u_asm (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_xfer && (r_state == LDR_HDR1)),
      .i_en         (w_xfer && (r_state == LDR_DATA)),
      .i_byte       (in_data),
      .o_byte_idx   (w_byte_idx),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= LDR_HDR0;
         r_count    <= 16'd0;
         r_word_idx <= 16'd0;
         r_last     <= 1'b0;
         r_addr     <= ADDR_WIDTH'(BASE_ADDR);
         r_cpu_rst  <= 1'b1;
         r_pc_stall <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            LDR_HDR0: begin
               if (w_xfer) begin
                  r_count[7:0] <= in_data;
                  r_state      <= LDR_HDR1;
               end
            end
            LDR_HDR1: begin
               if (w_xfer) begin
                  r_count    <= w_hdr_n;
                  r_word_idx <= 16'd0;
                  r_last     <= 1'b0;
                  if (w_hdr_n == 16'd0) begin
                     r_state   <= LDR_REL_RST;
                     r_cpu_rst <= 1'b0;
                  end else if (w_hdr_n > LP_MAX) begin
                     r_state <= LDR_ERROR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= LDR_DATA;
                  end
               end
            end
            LDR_DATA: begin
               if (w_xfer && (w_byte_idx == 2'd3)) begin
                  r_addr     <= word_byte_addr(ADDR_WIDTH'(BASE_ADDR), r_word_idx);
                  r_word_idx <= r_word_idx + 16'd1;
                  if (r_word_idx == (r_count - 16'd1))
                     r_last <= 1'b1;
               end
               if (w_word_valid && r_last) begin
                  r_state   <= LDR_REL_RST;
                  r_cpu_rst <= 1'b0;
               end
            end
            LDR_REL_RST: begin
               r_state    <= LDR_REL_STALL;
               r_pc_stall <= 1'b0;
               r_done     <= 1'b1;
            end
            LDR_REL_STALL: r_state <= LDR_RUN;
            LDR_RUN, LDR_ERROR: r_state <= r_state;
            default: r_state <= LDR_HDR0;
         endcase
      end
   end

   assign in_ready = w_ready;
   assign w_addr   = r_addr;
   assign w_dat    = w_word;
   assign w_enb    = w_word_valid && (r_state == LDR_DATA);
   assign byte_enb = {4{w_enb}};
   assign cpu_rst  = r_cpu_rst;
   assign pc_stall = r_pc_stall;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_bram_program_loader.sv
// Directed bench for bram_program_loader: image load, throttled input, empty and
// oversized headers, and mid-load reset, with hand-computed expected values.
module tb_bram_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [11:0] w_addr;
   logic [31:0] w_dat;
   logic        w_enb;
   logic [3:0]  byte_enb;
   logic        cpu_rst;
   logic        pc_stall;
   logic        done;
   logic        err;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_wr    = 0;
   logic [11:0] wa [8];
   logic [31:0] wd [8];
   logic [3:0]  be [8];
   logic [7:0]  img [10];

   bram_program_loader dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .w_addr   (w_addr),
      .w_dat    (w_dat),
      .w_enb    (w_enb),
      .byte_enb (byte_enb),
      .cpu_rst  (cpu_rst),
      .pc_stall (pc_stall),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Write monitor on the falling edge; cleared whenever reset is seen.
   always @(negedge clk) begin
      if (rst) begin
         n_wr = 0;
      end else if (w_enb) begin
         if (n_wr < 8) begin
            wa[n_wr] = w_addr;
            wd[n_wr] = w_dat;
            be[n_wr] = byte_enb;
         end
         n_wr++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      for (int i = 0; i < 100 && !ok; i++) begin
         ok = in_ready;
         tick();
      end
      chk("byte_accepted", ok, 1);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Sends the two-word image; throttle=1 toggles in_valid and inserts a 20-cycle gap.
   task automatic load_image(input bit throttle);
      for (int i = 0; i < 10; i++) begin
         if (throttle) idle(1);
         send(img[i]);
         if (throttle && i == 3) idle(20);
         if (i == 5) begin
            chk("w0_enb",   w_enb,    1);
            chk("w0_addr",  w_addr,   12'h000);
            chk("w0_dat",   w_dat,    32'h00500013);
            chk("w0_be",    byte_enb, 4'hF);
            chk("w0_ready", in_ready, 1);
         end else if (i == 9) begin
            chk("w1_enb",   w_enb,    1);
            chk("w1_addr",  w_addr,   12'h004);
            chk("w1_dat",   w_dat,    32'h00100093);
            chk("w1_ready", in_ready, 0);
            chk("w1_cpurst", cpu_rst, 1);
         end else if (i >= 2) begin
            chk("no_early_wenb", w_enb, 0);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("rel_wenb_low", w_enb,    0);
      chk("rel_cpu_rst",  cpu_rst,  0);
      chk("rel_stall_hi", pc_stall, 1);
      chk("rel_done_lo",  done,     0);
      tick();
      chk("rel_stall_lo", pc_stall, 0);
      chk("rel_done",     done,     1);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      tick();
      chk("run_ready", in_ready, 0);
      in_valid = 1'b0;
      tick();
      chk("wr_count", n_wr, 2);
      chk("mon_addr0", wa[0], 12'h000);
      chk("mon_dat0",  wd[0], 32'h00500013);
      chk("mon_addr1", wa[1], 12'h004);
      chk("mon_dat1",  wd[1], 32'h00100093);
      chk("mon_be1",   be[1], 4'hF);
   endtask

   initial begin
      img[0] = 8'h02; img[1] = 8'h00;
      img[2] = 8'h13; img[3] = 8'h00; img[4] = 8'h50; img[5] = 8'h00;
      img[6] = 8'h93; img[7] = 8'h00; img[8] = 8'h10; img[9] = 8'h00;

      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      tick();
      chk("rst_ready",    in_ready, 0);
      chk("rst_addr",     w_addr,   12'h000);
      chk("rst_dat",      w_dat,    32'h0);
      chk("rst_wenb",     w_enb,    0);
      chk("rst_be",       byte_enb, 4'h0);
      chk("rst_cpu_rst",  cpu_rst,  1);
      chk("rst_pc_stall", pc_stall, 1);
      chk("rst_done",     done,     0);
      chk("rst_err",      err,      0);
      tick();
      rst = 1'b0;
      chk("hdr0_ready", in_ready, 1);

      load_image(1'b0);

      do_reset();
      load_image(1'b1);

      // Empty image: release straight from the header.
      do_reset();
      send(8'h00);
      send(8'h00);
      chk("n0_cpu_rst", cpu_rst,  0);
      chk("n0_stall",   pc_stall, 1);
      chk("n0_wenb",    w_enb,    0);
      in_valid = 1'b0;
      tick();
      chk("n0_stall_lo", pc_stall, 0);
      chk("n0_done",     done,     1);
      in_valid = 1'b1;
      in_data  = 8'h55;
      chk("n0_ready", in_ready, 0);
      tick();
      tick();
      in_valid = 1'b0;
      chk("n0_wr", n_wr, 0);
      chk("n0_err", err, 0);

      // Largest legal count must not raise err.
      do_reset();
      send(8'h00);
      send(8'h04);
      chk("max_err",   err,      0);
      chk("max_ready", in_ready, 1);
      chk("max_rst",   cpu_rst,  1);

      // Oversized header: sticky error, bytes drained with no writes.
      do_reset();
      send(8'h01);
      send(8'h04);
      chk("ovf_err",   err,      1);
      chk("ovf_rst",   cpu_rst,  1);
      chk("ovf_stall", pc_stall, 1);
      chk("ovf_ready", in_ready, 1);
      for (int i = 0; i < 8; i++) send(8'(i + 8'h40));
      in_valid = 1'b0;
      tick();
      chk("ovf_wr",    n_wr, 0);
      chk("ovf_done",  done, 0);
      chk("ovf_err2",  err,  1);

      // Reset in the middle of the first word's write cycle.
      do_reset();
      for (int i = 0; i < 6; i++) send(img[i]);
      chk("mid_wenb", w_enb, 1);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 0);
      tick();
      chk("mid_addr",  w_addr,   12'h000);
      chk("mid_dat",   w_dat,    32'h0);
      chk("mid_wenb0", w_enb,    0);
      chk("mid_be",    byte_enb, 4'h0);
      chk("mid_cpu",   cpu_rst,  1);
      chk("mid_stall", pc_stall, 1);
      chk("mid_done",  done,     0);
      rst = 1'b0;
      chk("mid_ready", in_ready, 1);
      load_image(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
